// File: rtl/eight_data_compress_unit_pkg.sv
// Shared constants, tag codes and stage bundle for the eight-lane word compressor.
// Also holds the tag-to-byte-count helper used by the lane classifier.
package eight_data_compress_unit_pkg;

  localparam int NUM_COMPRESS_UNITS = 8;
  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH = 2;
  localparam int LEN_WIDTH = 8;
  localparam int OFF_WIDTH = 6;

  localparam logic [1:0] TAG_ZERO = 2'b00;
  localparam logic [1:0] TAG_B1 = 2'b01;
  localparam logic [1:0] TAG_B2 = 2'b10;
  localparam logic [1:0] TAG_RAW = 2'b11;

  localparam int FLAG_VALID = 3;
  localparam int FLAG_LAST = 2;
  localparam int FLAG_COMPRESS = 1;
  localparam int FLAG_HEADER = 0;

  typedef struct packed {
    logic [NUM_COMPRESS_UNITS-1:0][TAG_WIDTH-1:0] tags;
    logic [NUM_COMPRESS_UNITS-1:0][OFF_WIDTH-1:0] offs;
    logic [NUM_COMPRESS_UNITS-1:0][DATA_WIDTH-1:0] data;
    logic [OFF_WIDTH-1:0] len;
    logic [3:0] flags;
  } cmp_s1_t;

  function automatic logic [2:0] byteCount(input logic [1:0] tag);
    logic [2:0] n;
    unique case (tag)
      TAG_ZERO: n = 3'd0;
      TAG_B1: n = 3'd1;
      TAG_B2: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/word_compress_classifier.sv
// Classifies one 32-bit lane word into a size class.
// Payload carries only the surviving low bytes; upper bytes are zeroed.
module word_compress_classifier
  import eight_data_compress_unit_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] word,
  output logic [TAG_WIDTH-1:0]  tag,
  output logic [2:0]            byteCnt,
  output logic [DATA_WIDTH-1:0] payload
);

  logic isZero;
  logic fits8;
  logic fits16;

  assign isZero = (word == '0);
  assign fits8 = (word == {{24{word[7]}}, word[7:0]});
  assign fits16 = (word == {{16{word[15]}}, word[15:0]});

  // Zero always fits in a byte, so the terms below never overlap.
  always_comb begin
    tag = TAG_RAW;
    payload = word;
    unique case (1'b1)
      isZero: begin
        tag = TAG_ZERO;
        payload = '0;
      end
      fits8 && !isZero: begin
        tag = TAG_B1;
        payload = {24'h0, word[7:0]};
      end
      fits16 && !fits8: begin
        tag = TAG_B2;
        payload = {16'h0, word[15:0]};
      end
      !fits16: begin
        tag = TAG_RAW;
        payload = word;
      end
      default: begin
        tag = TAG_RAW;
        payload = word;
      end
    endcase
  end

  assign byteCnt = byteCount(tag);

endmodule

// File: rtl/eight_data_compress_unit.sv
// Eight-lane word compressor: classify, prefix-sum offsets, then byte-pack.
// Two register stages; wrtEn low freezes both.
module eight_data_compress_unit
  import eight_data_compress_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         wrtEn,
  input  logic [3:0]   flags_in,
  input  logic [255:0] dataIn,
  output logic [255:0] dataOut,
  output logic [15:0]  tagOut,
  output logic [7:0]   lenOut,
  output logic [3:0]   flags_out
);

  logic [NUM_COMPRESS_UNITS-1:0][TAG_WIDTH-1:0] laneTag;
  logic [NUM_COMPRESS_UNITS-1:0][2:0] laneCnt;
  logic [NUM_COMPRESS_UNITS-1:0][DATA_WIDTH-1:0] lanePay;

  for (genvar g = 0; g < NUM_COMPRESS_UNITS; g++) begin : gLane
    word_compress_classifier uCls (
      .word    (dataIn[DATA_WIDTH*g +: DATA_WIDTH]),
      .tag     (laneTag[g]),
      .byteCnt (laneCnt[g]),
      .payload (lanePay[g])
    );
  end

  cmp_s1_t s1Next;
  cmp_s1_t s1;
  logic bypass;
  logic [OFF_WIDTH-1:0] acc;
  logic [2:0] cnt;

  // Bypass is expressed as every lane raw at 4 bytes, so the packer
  // reproduces dataIn without a separate path.
  always_comb begin
    s1Next = '0;
    bypass = 1'b0;
    acc = '0;
    cnt = '0;
    s1Next.flags = flags_in;
    if (flags_in[FLAG_VALID]) begin
      bypass = flags_in[FLAG_HEADER] || !flags_in[FLAG_COMPRESS];
      for (int i = 0; i < NUM_COMPRESS_UNITS; i++) begin
        cnt = bypass ? 3'd4 : laneCnt[i];
        s1Next.tags[i] = bypass ? TAG_RAW : laneTag[i];
        s1Next.data[i] = bypass ? dataIn[DATA_WIDTH*i +: DATA_WIDTH]
                                : lanePay[i];
        s1Next.offs[i] = acc;
        acc = acc + {3'b000, cnt};
      end
      s1Next.len = acc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
    end else if (wrtEn) begin
      s1 <= s1Next;
    end
  end

  logic [255:0] packed_q;

  always_comb begin
    packed_q = '0;
    for (int i = 0; i < NUM_COMPRESS_UNITS; i++) begin
      packed_q = packed_q
        | ({224'h0, s1.data[i]} << {s1.offs[i], 3'b000});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataOut <= '0;
      tagOut <= '0;
      lenOut <= '0;
      flags_out <= '0;
    end else if (wrtEn) begin
      dataOut <= packed_q;
      tagOut <= s1.tags;
      lenOut <= {2'b00, s1.len};
      flags_out <= s1.flags;
    end
  end

endmodule

// File: tb/tb_eight_data_compress_unit.sv
// Directed bench for eight_data_compress_unit.
// Hand-computed vectors through a single checking task.
module tb_eight_data_compress_unit;

  logic         clk;
  logic         reset;
  logic         wrtEn;
  logic [3:0]   flags_in;
  logic [255:0] dataIn;
  logic [255:0] dataOut;
  logic [15:0]  tagOut;
  logic [7:0]   lenOut;
  logic [3:0]   flags_out;

  int errs = 0;
  int checks = 0;

  eight_data_compress_unit dut (
    .clk       (clk),
    .reset     (reset),
    .wrtEn     (wrtEn),
    .flags_in  (flags_in),
    .dataIn    (dataIn),
    .dataOut   (dataOut),
    .tagOut    (tagOut),
    .lenOut    (lenOut),
    .flags_out (flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chkOut(input string tag, input logic [255:0] eData,
                        input logic [15:0] eTag, input logic [7:0] eLen,
                        input logic [3:0] eFlags);
    chk({tag, ".data"}, dataOut, eData);
    chk({tag, ".tag"}, {240'h0, tagOut}, {240'h0, eTag});
    chk({tag, ".len"}, {248'h0, lenOut}, {248'h0, eLen});
    chk({tag, ".flags"}, {252'h0, flags_out}, {252'h0, eFlags});
  endtask

  task automatic beat(input string tag, input logic [3:0] f,
                      input logic [255:0] d, input logic [255:0] eData,
                      input logic [15:0] eTag, input logic [7:0] eLen);
    flags_in = f;
    dataIn = d;
    step();
    flags_in = 4'b0000;
    dataIn = '0;
    step();
    chkOut(tag, eData, eTag, eLen, f);
  endtask

  logic [255:0] rawD;
  logic [255:0] mixD;
  logic [255:0] mixE;
  logic [255:0] edgeD;
  logic [255:0] edgeE;

  initial begin
    rawD = {8{32'hBA98FEDC}};
    mixD = {32'h0, 32'h0, 32'h0, 32'h0,
            32'h12345678, 32'h00001234, 32'hFFFFFF80, 32'h0000007F};
    mixE = {192'h0, 64'h12345678_1234_80_7F};
    edgeD = {32'hFFFF8000, {7{32'h0000007F}}};
    edgeE = {184'h0, 72'h80_00_7F7F7F7F7F7F7F};

    reset = 1'b1;
    wrtEn = 1'b0;
    flags_in = 4'b1011;
    dataIn = rawD;
    repeat (3) step();
    chkOut("reset", '0, 16'h0, 8'd0, 4'b0000);

    reset = 1'b0;
    wrtEn = 1'b1;
    beat("header", 4'b1011, rawD, rawD, 16'hFFFF, 8'd32);
    beat("incomp", 4'b1010, rawD, rawD, 16'hFFFF, 8'd32);
    beat("nocomp", 4'b1000, mixD, mixD, 16'hFFFF, 8'd32);
    beat("zeros", 4'b1110, '0, '0, 16'h0000, 8'd0);
    beat("mixed", 4'b1010, mixD, mixE, 16'h00E5, 8'd8);
    beat("edge", 4'b1010, edgeD, edgeE, 16'h9555, 8'd9);
    beat("invalid", 4'b0110, rawD, '0, 16'h0000, 8'd0);

    // back-to-back beats, one result per cycle
    flags_in = 4'b1010;
    dataIn = mixD;
    step();
    flags_in = 4'b1110;
    dataIn = edgeD;
    step();
    flags_in = 4'b0000;
    dataIn = '0;
    chkOut("b2b0", mixE, 16'h00E5, 8'd8, 4'b1010);
    step();
    chkOut("b2b1", edgeE, 16'h9555, 8'd9, 4'b1110);
    step();
    chkOut("idle", '0, 16'h0, 8'd0, 4'b0000);

    // hold: beat sits in stage 1 while wrtEn is low
    flags_in = 4'b1010;
    dataIn = mixD;
    step();
    wrtEn = 1'b0;
    flags_in = 4'b1011;
    dataIn = rawD;
    for (int i = 0; i < 3; i++) begin
      step();
      chkOut("hold", '0, 16'h0, 8'd0, 4'b0000);
    end
    wrtEn = 1'b1;
    flags_in = 4'b0000;
    dataIn = '0;
    step();
    chkOut("release", mixE, 16'h00E5, 8'd8, 4'b1010);

    // asynchronous reset mid-stream
    flags_in = 4'b1011;
    dataIn = rawD;
    step();
    step();
    chkOut("prerst", rawD, 16'hFFFF, 8'd32, 4'b1011);
    #2;
    reset = 1'b1;
    #1;
    chkOut("asyncrst", '0, 16'h0, 8'd0, 4'b0000);
    step();
    reset = 1'b0;
    flags_in = 4'b0000;
    dataIn = '0;
    step();
    chkOut("postrst", '0, 16'h0, 8'd0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
